// File: rtl/cache_line_fill_ctrl_if.sv
// Miss-request, burst-read and RAM write-port signals of the line fill engine.
// master = fill engine, slave = the requester/memory/RAM environment around it.
interface cache_line_fill_ctrl_if #(
  parameter int DEPTH      = 512,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(LINE_WORDS);

  logic                   FLUSH;
  logic                   MISS_VALID;
  logic [ADDR_WIDTH-1:0]  MISS_ADDR;
  logic                   MISS_READY;
  logic                   MEM_ARVALID;
  logic [ADDR_WIDTH-1:0]  MEM_ARADDR;
  logic [7:0]             MEM_ARLEN;
  logic                   MEM_ARREADY;
  logic                   MEM_RVALID;
  logic [DATA_WIDTH-1:0]  MEM_RDATA;
  logic                   MEM_RLAST;
  logic                   MEM_RREADY;
  logic                   LINE_WREN;
  logic [IDX_W+OFF_W-1:0] LINE_WADDR;
  logic [DATA_WIDTH-1:0]  LINE_WDATA;
  logic                   STATE_WREN;
  logic [IDX_W-1:0]       STATE_WADDR;
  logic                   STATE_DATA;
  logic                   FILL_DONE;
  logic                   FILL_ERR;

  modport master (
    input  FLUSH, MISS_VALID, MISS_ADDR, MEM_ARREADY, MEM_RVALID, MEM_RDATA, MEM_RLAST,
    output MISS_READY, MEM_ARVALID, MEM_ARADDR, MEM_ARLEN, MEM_RREADY,
    output LINE_WREN, LINE_WADDR, LINE_WDATA, STATE_WREN, STATE_WADDR, STATE_DATA,
    output FILL_DONE, FILL_ERR
  );

  modport slave (
    output FLUSH, MISS_VALID, MISS_ADDR, MEM_ARREADY, MEM_RVALID, MEM_RDATA, MEM_RLAST,
    input  MISS_READY, MEM_ARVALID, MEM_ARADDR, MEM_ARLEN, MEM_RREADY,
    input  LINE_WREN, LINE_WADDR, LINE_WDATA, STATE_WREN, STATE_WADDR, STATE_DATA,
    input  FILL_DONE, FILL_ERR
  );
endinterface

// File: rtl/cache_line_fill_ctrl.sv
// Direct-mapped cache refill engine: invalidates the set, bursts the line into the data RAM,
// then marks the set valid only if the burst was complete, well-formed and not flushed.
module cache_line_fill_ctrl #(
  parameter int DEPTH      = 512,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  cache_line_fill_ctrl_if.master bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int BO_W  = $clog2(DATA_WIDTH / 8);
  localparam int LA_W  = ADDR_WIDTH - OFF_W - BO_W;

  typedef enum logic [2:0] {IDLE, REQ, BEAT, COMMIT, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [LA_W-1:0]   line_q, line_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;

  logic [IDX_W-1:0]  idx;
  logic              cnt_last;
  logic              unused_bits;

  assign idx         = line_q[IDX_W-1:0];
  assign cnt_last    = (cnt_q == OFF_W'(LINE_WORDS - 1));
  assign unused_bits = ^bus.MISS_ADDR[OFF_W+BO_W-1:0];

  assign bus.MEM_ARADDR = {line_q, {(OFF_W+BO_W){1'b0}}};
  assign bus.MEM_ARLEN  = 8'(LINE_WORDS - 1);
  assign bus.LINE_WADDR = {idx, cnt_q};
  assign bus.LINE_WDATA = bus.MEM_RDATA;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      line_q  <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    line_d          = line_q;
    cnt_d           = cnt_q;
    abort_d         = abort_q;
    bus.MISS_READY  = 1'b0;
    bus.MEM_ARVALID = 1'b0;
    bus.MEM_RREADY  = 1'b0;
    bus.LINE_WREN   = 1'b0;
    bus.STATE_WREN  = 1'b0;
    bus.STATE_WADDR = idx;
    bus.STATE_DATA  = 1'b0;
    bus.FILL_DONE   = 1'b0;
    bus.FILL_ERR    = 1'b0;

    case (state_q)
      IDLE: begin
        bus.MISS_READY = 1'b1;
        if (bus.MISS_VALID && !bus.FLUSH) begin
          // Invalidate before any beat lands so a hit can never see a half-written line.
          line_d          = bus.MISS_ADDR[ADDR_WIDTH-1:OFF_W+BO_W];
          cnt_d           = '0;
          abort_d         = 1'b0;
          state_d         = REQ;
          bus.STATE_WREN  = 1'b1;
          bus.STATE_WADDR = bus.MISS_ADDR[BO_W+OFF_W +: IDX_W];
        end
      end

      REQ: begin
        bus.MEM_ARVALID = 1'b1;
        if (bus.FLUSH) abort_d = 1'b1;
        if (bus.MEM_ARREADY) state_d = (abort_q || bus.FLUSH) ? DRAIN : BEAT;
      end

      BEAT: begin
        bus.MEM_RREADY = 1'b1;
        if (bus.FLUSH) begin
          state_d = (bus.MEM_RVALID && bus.MEM_RLAST) ? IDLE : DRAIN;
        end else if (bus.MEM_RVALID) begin
          bus.LINE_WREN = 1'b1;
          cnt_d         = cnt_q + 1'b1;
          if (bus.MEM_RLAST) begin
            if (cnt_last) begin
              state_d = COMMIT;
            end else begin
              bus.FILL_ERR = 1'b1;
              state_d      = IDLE;
            end
          end else if (cnt_last) begin
            // Memory is sending more beats than a line holds; swallow them.
            bus.FILL_ERR = 1'b1;
            state_d      = DRAIN;
          end
        end
      end

      COMMIT: begin
        if (!bus.FLUSH) begin
          bus.STATE_WREN = 1'b1;
          bus.STATE_DATA = 1'b1;
          bus.FILL_DONE  = 1'b1;
        end
        state_d = IDLE;
      end

      DRAIN: begin
        bus.MEM_RREADY = 1'b1;
        if (bus.MEM_RVALID && bus.MEM_RLAST) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Directed vector table for the line fill engine plus a hand-driven gapped-burst sequence.
module tb_cache_line_fill_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  cache_line_fill_ctrl_if bus ();

  cache_line_fill_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  // flags = {MISS_READY, ARVALID, RREADY, LINE_WREN, STATE_WREN, STATE_DATA, FILL_DONE, FILL_ERR}
  typedef struct {
    logic        rst, fl, mv;
    logic [31:0] addr;
    logic        ardy, rv, rl;
    logic [31:0] rdata;
    bit          chk;
    logic [7:0]  flags;
    logic [11:0] lwa;
    logic [8:0]  swa;
    logic [31:0] ara;
  } vec_t;

  vec_t vq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic push(input logic rst, input logic fl, input logic mv, input logic [31:0] a,
                      input logic ardy, input logic rv, input logic rl, input bit chk,
                      input logic [7:0] fg, input logic [11:0] lwa, input logic [8:0] swa,
                      input logic [31:0] ara);
    vec_t v;
    v.rst = rst; v.fl = fl; v.mv = mv; v.addr = a;
    v.ardy = ardy; v.rv = rv; v.rl = rl;
    v.rdata = 32'hD000_0000 | 32'(vq.size());
    v.chk = chk; v.flags = fg; v.lwa = lwa; v.swa = swa; v.ara = ara;
    vq.push_back(v);
  endtask

  task automatic t_rst(input logic rv);
    push(1, 0, 0, 0, 0, rv, 0, 0, 8'h00, 0, 0, 0);
  endtask
  task automatic t_idle();
    push(0, 0, 0, 0, 0, 0, 0, 1, 8'h80, 0, 0, 0);
  endtask
  task automatic t_miss(input logic [31:0] a, input logic fl);
    push(0, fl, 1, a, 0, 0, 0, 1, fl ? 8'h80 : 8'h88, 0, a[13:5], 0);
  endtask
  task automatic t_req(input logic ardy, input logic fl, input logic [31:0] ara);
    push(0, fl, 0, 0, ardy, 0, 0, 1, 8'h40, 0, 0, ara);
  endtask
  task automatic t_beat(input logic rv, input logic rl, input logic fl, input logic [7:0] fg,
                        input logic [11:0] lwa);
    push(0, fl, 0, 0, 0, rv, rl, 1, fg, lwa, 0, 0);
  endtask
  task automatic t_commit(input logic fl, input logic [8:0] idx);
    push(0, fl, 0, 0, 0, 0, 0, 1, fl ? 8'h00 : 8'h0E, 0, idx, 0);
  endtask

  task automatic check(input string name, input bit ok, input logic [31:0] got,
                       input logic [31:0] want);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic build();
    t_rst(0); t_rst(0); t_idle();
    // Basic fill of 0x1234 -> set 0x091
    t_miss(32'h0000_1234, 0); t_req(1, 0, 32'h0000_1220);
    for (int i = 0; i < 8; i++) t_beat(1, i == 7, 0, 8'h30, {9'h091, 3'(i)});
    t_commit(0, 9'h091); t_idle();
    // Miss coincident with FLUSH is refused
    t_miss(32'h0000_1234, 1); t_idle();
    // FLUSH on the third beat
    t_miss(32'h0000_ABC0, 0); t_req(1, 0, 32'h0000_ABC0);
    t_beat(1, 0, 0, 8'h30, {9'h15E, 3'd0}); t_beat(1, 0, 0, 8'h30, {9'h15E, 3'd1});
    t_beat(1, 0, 1, 8'h20, 0);
    for (int i = 3; i < 8; i++) t_beat(1, i == 7, 0, 8'h20, 0);
    t_idle(); t_idle();
    // FLUSH while the request is still waiting for ARREADY
    t_miss(32'h0004_0F00, 0); t_req(0, 1, 32'h0004_0F00); t_req(0, 0, 32'h0004_0F00);
    t_req(1, 0, 32'h0004_0F00);
    for (int i = 0; i < 8; i++) t_beat(1, i == 7, 0, 8'h20, 0);
    t_idle();
    // RLAST on beat 5
    t_miss(32'h0000_0040, 0); t_req(1, 0, 32'h0000_0040);
    for (int i = 0; i < 4; i++) t_beat(1, 0, 0, 8'h30, {9'h002, 3'(i)});
    t_beat(1, 1, 0, 8'h31, {9'h002, 3'd4}); t_idle();
    // No RLAST on beat 8
    t_miss(32'h0000_0060, 0); t_req(1, 0, 32'h0000_0060);
    for (int i = 0; i < 7; i++) t_beat(1, 0, 0, 8'h30, {9'h003, 3'(i)});
    t_beat(1, 0, 0, 8'h31, {9'h003, 3'd7});
    t_beat(0, 0, 0, 8'h20, 0); t_beat(1, 1, 0, 8'h20, 0); t_idle();
    // RST in the middle of a burst
    t_miss(32'h0000_0080, 0); t_req(1, 0, 32'h0000_0080);
    t_beat(1, 0, 0, 8'h30, {9'h004, 3'd0}); t_rst(1); t_idle(); t_idle();
    // FLUSH coincident with COMMIT
    t_miss(32'h0000_00A0, 0); t_req(1, 0, 32'h0000_00A0);
    for (int i = 0; i < 8; i++) t_beat(1, i == 7, 0, 8'h30, {9'h005, 3'(i)});
    t_commit(1, 9'h005); t_idle();
  endtask

  task automatic apply(input int k);
    logic [7:0] got;
    bit         ok;
    @(negedge CLK);
    RST = vq[k].rst; bus.FLUSH = vq[k].fl; bus.MISS_VALID = vq[k].mv; bus.MISS_ADDR = vq[k].addr;
    bus.MEM_ARREADY = vq[k].ardy; bus.MEM_RVALID = vq[k].rv; bus.MEM_RLAST = vq[k].rl;
    bus.MEM_RDATA = vq[k].rdata;
    #2;
    if (vq[k].chk) begin
      got = {bus.MISS_READY, bus.MEM_ARVALID, bus.MEM_RREADY, bus.LINE_WREN,
             bus.STATE_WREN, bus.STATE_DATA, bus.FILL_DONE, bus.FILL_ERR};
      ok = (got === vq[k].flags) && (bus.MEM_ARLEN === 8'd7);
      if (vq[k].flags[4]) ok &= (bus.LINE_WADDR === vq[k].lwa) && (bus.LINE_WDATA === vq[k].rdata);
      if (vq[k].flags[3]) ok &= (bus.STATE_WADDR === vq[k].swa);
      if (vq[k].flags[6]) ok &= (bus.MEM_ARADDR === vq[k].ara);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL vec%0d: flags=%b waddr=%h swaddr=%h araddr=%h wdata=%h arlen=%0d; expected flags=%b waddr=%h swaddr=%h araddr=%h wdata=%h",
                 k, got, bus.LINE_WADDR, bus.STATE_WADDR, bus.MEM_ARADDR, bus.LINE_WDATA,
                 bus.MEM_ARLEN, vq[k].flags, vq[k].lwa, vq[k].swa, vq[k].ara, vq[k].rdata);
      end
    end
  endtask

  // ARREADY held off 5 cycles, one beat every third cycle.
  task automatic gap_seq();
    bit stable = 1'b1;
    bit order_ok = 1'b1;
    bit found = 1'b0;
    int wr = 0;
    @(negedge CLK);
    bus.MISS_VALID = 1'b1; bus.MISS_ADDR = 32'h0000_3FE4;
    #2;
    check("gap_invalidate", bus.STATE_WREN === 1'b1 && bus.STATE_DATA === 1'b0 &&
          bus.STATE_WADDR === 9'h1FF, {22'd0, bus.STATE_WREN, bus.STATE_WADDR}, {22'd1, 1'b0, 9'h1FF});
    @(negedge CLK);
    bus.MISS_VALID = 1'b0; bus.MEM_ARREADY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2 stable &= (bus.MEM_ARVALID === 1'b1) && (bus.MEM_ARADDR === 32'h0000_3FE0);
      @(negedge CLK);
    end
    bus.MEM_ARREADY = 1'b1;
    #2 stable &= (bus.MEM_ARVALID === 1'b1) && (bus.MEM_ARADDR === 32'h0000_3FE0);
    check("gap_ar_stable", stable, bus.MEM_ARADDR, 32'h0000_3FE0);
    @(negedge CLK);
    bus.MEM_ARREADY = 1'b0;
    for (int b = 0; b < 8; b++) begin
      bus.MEM_RVALID = 1'b1; bus.MEM_RDATA = 32'hC0DE_0000 + 32'(b); bus.MEM_RLAST = (b == 7);
      #2;
      if (bus.LINE_WREN === 1'b1) begin
        wr++;
        order_ok &= (bus.LINE_WADDR === {9'h1FF, 3'(b)}) && (bus.LINE_WDATA === 32'hC0DE_0000 + 32'(b));
      end
      @(negedge CLK);
      bus.MEM_RVALID = 1'b0; bus.MEM_RLAST = 1'b0;
      if (b < 7) begin
        for (int g = 0; g < 2; g++) begin
          #2 if (bus.LINE_WREN !== 1'b0) begin wr++; order_ok = 1'b0; end
          @(negedge CLK);
        end
      end
    end
    for (int t = 0; t < 10 && !found; t++) begin
      #2;
      if (bus.FILL_DONE === 1'b1) found = 1'b1;
      else @(negedge CLK);
    end
    check("gap_fill_done", found, 32'(found), 32'd1);
    check("gap_commit", bus.STATE_WREN === 1'b1 && bus.STATE_DATA === 1'b1 &&
          bus.STATE_WADDR === 9'h1FF, {22'd0, bus.STATE_DATA, bus.STATE_WADDR}, {22'd1, 1'b1, 9'h1FF});
    check("gap_wr_count", wr == 8, 32'(wr), 32'd8);
    check("gap_wr_order", order_ok, 32'(order_ok), 32'd1);
    @(negedge CLK);
    #2;
    check("gap_ready_after", bus.MISS_READY === 1'b1 && bus.FILL_DONE === 1'b0,
          {30'd0, bus.MISS_READY, bus.FILL_DONE}, 32'd2);
  endtask

  initial begin
    bus.FLUSH = 1'b0; bus.MISS_VALID = 1'b0; bus.MISS_ADDR = '0;
    bus.MEM_ARREADY = 1'b0; bus.MEM_RVALID = 1'b0; bus.MEM_RDATA = '0; bus.MEM_RLAST = 1'b0;
    build();
    for (int k = 0; k < vq.size(); k++) apply(k);
    @(negedge CLK);
    RST = 1'b0; bus.FLUSH = 1'b0; bus.MISS_VALID = 1'b0;
    bus.MEM_ARREADY = 1'b0; bus.MEM_RVALID = 1'b0; bus.MEM_RLAST = 1'b0;
    gap_seq();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
